// File: rtl/req_queue_pkg.sv
// Shared defaults and grant-vector helpers for the request queue bank.
package req_queue_pkg;
    localparam int N_DEF     = 3;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 4;

    function automatic int onehot_to_idx(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = idx | i;
        end
        return idx;
    endfunction

    // True when zero or exactly one bit is set.
    function automatic logic is_onehot0(input logic [31:0] v);
        return (v & (v - 32'd1)) == 32'd0;
    endfunction
endpackage

// File: rtl/req_fifo.sv
// Single-requester circular-buffer FIFO; head is visible combinationally.
module req_fifo
    import req_queue_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full queue refuses a push even if it is popped in the same cycle.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/req_queue_bank.sv
// Per-requester FIFOs feeding a 4-way arbiter; grants pop the head to one output port.
module req_queue_bank
    import req_queue_pkg::*;
#(
    parameter int n     = N_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [n:0]               in_valid,
    input  logic [(n+1)*DW-1:0]      in_data,
    output logic [n:0]               in_ready,
    output logic [n:0]               req,
    input  logic [n:0]               gnt,
    output logic                     out_valid,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(n+1)-1:0]   out_id,
    output logic                     err_gnt
);
    localparam int IW = $clog2(n+1);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] head  [n+1];
    logic [CW-1:0] count [n+1];
    logic [n:0]    full;
    logic [n:0]    empty;
    logic [n:0]    pop;
    logic          gnt_legal;
    logic [IW-1:0] gnt_idx;

    // An illegal grant pops nothing, so every queue stays untouched.
    assign gnt_legal = is_onehot0(32'(gnt)) && ((gnt & ~req) == '0);
    assign pop       = gnt_legal ? gnt : '0;
    assign gnt_idx   = IW'(onehot_to_idx(32'(gnt)));

    for (genvar i = 0; i <= n; i++) begin : g_q
        req_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_valid[i]),
            .pop   (pop[i]),
            .din   (in_data[i*DW +: DW]),
            .head  (head[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .count (count[i])
        );
        assign in_ready[i] = ~full[i];
        assign req[i]      = ~empty[i];

        a_count_sane: assert property (@(posedge clk) disable iff (!rst)
            (count[i] <= CW'(DEPTH)) && (empty[i] == (count[i] == '0)));
    end

    // Output stage: one cycle after the grant edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            err_gnt   <= 1'b0;
        end else begin
            out_valid <= |pop;
            if (|pop) begin
                out_data <= head[gnt_idx];
                out_id   <= gnt_idx;
            end
            if (!gnt_legal) err_gnt <= 1'b1;
        end
    end
endmodule

// File: tb/tb_req_queue_bank.sv
// Bench for req_queue_bank: directed vector table, error/reset sequences, random run against a queue model.
module tb_req_queue_bank;
    localparam int N     = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        err_gnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    req_queue_bank #(.n(N), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .err_gnt   (err_gnt)
    );

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic [3:0]  req;
        logic [3:0]  rdy;
        logic        ov;
        logic [7:0]  od;
        logic [1:0]  oid;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] dat(input int i, input logic [7:0] b);
        return 32'(b) << (8 * i);
    endfunction

    task automatic add(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g,
                       input logic [3:0] rq, input logic [3:0] rd, input logic ov,
                       input logic [7:0] od, input logic [1:0] oid, input logic er);
        vec_t t;
        t.vld = v; t.data = d; t.gnt = g; t.req = rq; t.rdy = rd;
        t.ov = ov; t.od = od; t.oid = oid; t.err = er;
        tbl.push_back(t);
    endtask

    task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g);
        in_valid = v;
        in_data  = d;
        gnt      = g;
        @(posedge clk);
        #1;
        in_valid = '0;
        in_data  = '0;
        gnt      = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = '0;
        gnt = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Reference model: one queue of bytes per requester.
    logic [7:0] mq [4][$];
    logic       m_err;
    logic       m_ov;
    logic [7:0] m_od;
    logic [1:0] m_oid;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_err = 1'b0; m_ov = 1'b0; m_od = '0; m_oid = '0;
    endtask

    task automatic model_step(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g);
        int sz [4];
        int gi;
        logic legal;
        for (int i = 0; i < 4; i++) sz[i] = mq[i].size();
        gi = 0;
        for (int i = 0; i < 4; i++) if (g[i]) gi = i;
        legal = (g == 4'd0) || (($countones(g) == 1) && (sz[gi] > 0));
        if (!legal) m_err = 1'b1;
        m_ov = 1'b0;
        if (legal && g != 4'd0) begin
            m_ov  = 1'b1;
            m_od  = mq[gi].pop_front();
            m_oid = 2'(gi);
        end
        for (int i = 0; i < 4; i++)
            if (v[i] && sz[i] != DEPTH) mq[i].push_back(d[8*i +: 8]);
    endtask

    initial begin
        logic [3:0]  m_req;
        logic [3:0]  m_rdy;
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  g;
        int          r;
        int          k;

        rst = 1'b0;
        in_valid = '0;
        in_data = '0;
        gnt = '0;
        #1;
        chk("reset_req", 64'(req), 64'h0);
        chk("reset_rdy", 64'(in_ready), 64'hF);
        chk("reset_out", 64'({out_valid, out_data, out_id, err_gnt}), 64'h0);
        #6;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_req_rdy", 64'({req, in_ready}), 64'h0F);
        chk("idle_out", 64'({out_valid, out_data, out_id, err_gnt}), 64'h0);

        add(4'b0100, dat(2, 8'hA5), 4'b0000, 4'b0100, 4'hF, 1'b0, 8'h00, 2'd0, 1'b0);
        add(4'b0000, 32'h0,         4'b0100, 4'b0000, 4'hF, 1'b1, 8'hA5, 2'd2, 1'b0);
        add(4'b0001, dat(0, 8'h01), 4'b0000, 4'b0001, 4'hF, 1'b0, 8'hA5, 2'd2, 1'b0);
        add(4'b0001, dat(0, 8'h02), 4'b0000, 4'b0001, 4'hF, 1'b0, 8'hA5, 2'd2, 1'b0);
        add(4'b0001, dat(0, 8'h03), 4'b0000, 4'b0001, 4'hF, 1'b0, 8'hA5, 2'd2, 1'b0);
        add(4'b0001, dat(0, 8'h04), 4'b0000, 4'b0001, 4'hE, 1'b0, 8'hA5, 2'd2, 1'b0);
        add(4'b0001, dat(0, 8'h05), 4'b0000, 4'b0001, 4'hE, 1'b0, 8'hA5, 2'd2, 1'b0);
        add(4'b0000, 32'h0,         4'b0001, 4'b0001, 4'hF, 1'b1, 8'h01, 2'd0, 1'b0);
        add(4'b0000, 32'h0,         4'b0001, 4'b0001, 4'hF, 1'b1, 8'h02, 2'd0, 1'b0);
        add(4'b0000, 32'h0,         4'b0001, 4'b0001, 4'hF, 1'b1, 8'h03, 2'd0, 1'b0);
        add(4'b0000, 32'h0,         4'b0001, 4'b0000, 4'hF, 1'b1, 8'h04, 2'd0, 1'b0);
        add(4'b0001, dat(0, 8'h06), 4'b0000, 4'b0001, 4'hF, 1'b0, 8'h04, 2'd0, 1'b0);
        add(4'b0000, 32'h0,         4'b0001, 4'b0000, 4'hF, 1'b1, 8'h06, 2'd0, 1'b0);
        add(4'b0010, dat(1, 8'h11), 4'b0000, 4'b0010, 4'hF, 1'b0, 8'h06, 2'd0, 1'b0);
        add(4'b0010, dat(1, 8'h22), 4'b0000, 4'b0010, 4'hF, 1'b0, 8'h06, 2'd0, 1'b0);
        add(4'b0010, dat(1, 8'h33), 4'b0010, 4'b0010, 4'hF, 1'b1, 8'h11, 2'd1, 1'b0);
        add(4'b0000, 32'h0,         4'b0010, 4'b0010, 4'hF, 1'b1, 8'h22, 2'd1, 1'b0);
        add(4'b0000, 32'h0,         4'b0010, 4'b0000, 4'hF, 1'b1, 8'h33, 2'd1, 1'b0);
        add(4'b0000, 32'h0,         4'b0000, 4'b0000, 4'hF, 1'b0, 8'h33, 2'd1, 1'b0);
        add(4'b1000, dat(3, 8'h40), 4'b0000, 4'b1000, 4'hF, 1'b0, 8'h33, 2'd1, 1'b0);
        add(4'b1000, dat(3, 8'h41), 4'b0000, 4'b1000, 4'hF, 1'b0, 8'h33, 2'd1, 1'b0);
        add(4'b1000, dat(3, 8'h42), 4'b0000, 4'b1000, 4'hF, 1'b0, 8'h33, 2'd1, 1'b0);
        add(4'b1000, dat(3, 8'h43), 4'b0000, 4'b1000, 4'h7, 1'b0, 8'h33, 2'd1, 1'b0);
        add(4'b1000, dat(3, 8'h44), 4'b1000, 4'b1000, 4'hF, 1'b1, 8'h40, 2'd3, 1'b0);
        add(4'b0000, 32'h0,         4'b1000, 4'b1000, 4'hF, 1'b1, 8'h41, 2'd3, 1'b0);
        add(4'b0000, 32'h0,         4'b1000, 4'b1000, 4'hF, 1'b1, 8'h42, 2'd3, 1'b0);
        add(4'b0000, 32'h0,         4'b1000, 4'b0000, 4'hF, 1'b1, 8'h43, 2'd3, 1'b0);
        add(4'b0000, 32'h0,         4'b1000, 4'b0000, 4'hF, 1'b0, 8'h43, 2'd3, 1'b1);
        add(4'b0000, 32'h0,         4'b0000, 4'b0000, 4'hF, 1'b0, 8'h43, 2'd3, 1'b1);

        foreach (tbl[i]) begin
            cycle(tbl[i].vld, tbl[i].data, tbl[i].gnt);
            chk($sformatf("vec%0d_req_rdy", i), 64'({req, in_ready}), 64'({tbl[i].req, tbl[i].rdy}));
            chk($sformatf("vec%0d_out", i), 64'({out_valid, out_data, out_id}),
                64'({tbl[i].ov, tbl[i].od, tbl[i].oid}));
            chk($sformatf("vec%0d_err", i), 64'(err_gnt), 64'(tbl[i].err));
        end

        // Multi-bit grant: flagged, nothing popped, queues intact.
        do_reset();
        cycle(4'b0011, dat(0, 8'h5A) | dat(1, 8'hC3), 4'b0000);
        chk("multi_pre_req", 64'(req), 64'h3);
        cycle(4'b0000, 32'h0, 4'b0011);
        chk("multi_err", 64'(err_gnt), 64'h1);
        chk("multi_no_out", 64'(out_valid), 64'h0);
        chk("multi_req_kept", 64'(req), 64'h3);
        cycle(4'b0000, 32'h0, 4'b0010);
        chk("multi_then_pop", 64'({out_valid, out_data, out_id}), 64'({1'b1, 8'hC3, 2'd1}));

        // Grant of an empty queue right after reset.
        do_reset();
        chk("err_cleared", 64'(err_gnt), 64'h0);
        cycle(4'b0000, 32'h0, 4'b1000);
        chk("empty_gnt_err", 64'(err_gnt), 64'h1);
        chk("empty_gnt_no_out", 64'(out_valid), 64'h0);

        // Reset in the middle of traffic.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(4'hF, 32'h01020304 + 32'(i) * 32'h10101010, 4'b0000);
        chk("mid_filled_req", 64'(req), 64'hF);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 4'hF;
        in_data = 32'hDEADBEEF;
        gnt = 4'b0001;
        #1;
        chk("mid_rst_req_now", 64'({req, in_ready}), 64'h0F);
        @(posedge clk);
        #1;
        chk("mid_rst_req_edge", 64'({req, out_valid}), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        gnt = '0;
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0000, 32'h0, 4'(1 << i));
            chk($sformatf("mid_after_gnt%0d", i), 64'({out_valid, req}), 64'h0);
        end

        // Random traffic against the model.
        do_reset();
        model_clear();
        for (int c = 0; c < 600; c++) begin
            v = 4'($urandom_range(0, 15));
            d = $urandom;
            r = $urandom_range(0, 63);
            if (r == 0) g = 4'($urandom_range(0, 15));
            else if (r < 20) g = 4'b0000;
            else begin
                k = $urandom_range(0, 3);
                g = (mq[k].size() != 0) ? 4'(1 << k) : 4'b0000;
            end
            model_step(v, d, g);
            cycle(v, d, g);
            for (int i = 0; i < 4; i++) begin
                m_req[i] = (mq[i].size() != 0);
                m_rdy[i] = (mq[i].size() != DEPTH);
            end
            chk($sformatf("rnd%0d_req_rdy", c), 64'({req, in_ready}), 64'({m_req, m_rdy}));
            chk($sformatf("rnd%0d_out", c), 64'({out_valid, out_data, out_id, err_gnt}),
                64'({m_ov, m_od, m_oid, m_err}));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
